// File: rtl/axi_hs_pkg.sv
// Shared handshake constants: slice MODE selectors and the full-slice FSM encoding.
package axi_hs_pkg;
  localparam int HS_BYPASS = 0;
  localparam int HS_FWD    = 1;
  localparam int HS_BWD    = 2;
  localparam int HS_FULL   = 3;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  function automatic bit hs_mode_ok(input int mode);
    return (mode >= HS_BYPASS) && (mode <= HS_FULL);
  endfunction
endpackage

// File: rtl/axi_reg_slice.sv
// Valid/ready register slice; MODE picks bypass, forward reg, backward skid, or 2-entry full slice.
module axi_reg_slice
  import axi_hs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MODE       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_up,
  input  logic                  valid_up,
  output logic                  ready_up,
  output logic [DATA_WIDTH-1:0] data_down,
  output logic                  valid_down,
  input  logic                  ready_down,
  output logic [1:0]            occupancy
);

  if (MODE == HS_BYPASS) begin : g_bypass
    assign data_down  = data_up;
    assign valid_down = valid_up;
    assign ready_up   = ready_down;
    assign occupancy  = 2'd0;

  end else if (MODE == HS_FWD) begin : g_fwd
    logic                  v_r;
    logic [DATA_WIDTH-1:0] d_r;

    assign ready_up   = ready_down | ~v_r;
    assign valid_down = v_r;
    assign data_down  = d_r;
    assign occupancy  = {1'b0, v_r};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_r <= 1'b0;
        d_r <= '0;
      end else if (valid_up && ready_up) begin
        v_r <= 1'b1;
        d_r <= data_up;
      end else if (ready_down) begin
        v_r <= 1'b0;
      end
    end

  end else if (MODE == HS_BWD) begin : g_bwd
    logic                  skid_valid, skid_nxt, rdy_r;
    logic [DATA_WIDTH-1:0] skid_data;

    assign ready_up   = rdy_r;
    assign valid_down = valid_up | skid_valid;
    assign data_down  = skid_valid ? skid_data : data_up;
    assign occupancy  = {1'b0, skid_valid};

    // Skid fills only on a beat accepted into a stalled slave.
    assign skid_nxt = skid_valid ? ~ready_down : (valid_up & rdy_r & ~ready_down);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        skid_valid <= 1'b0;
        skid_data  <= '0;
        rdy_r      <= 1'b0;
      end else begin
        skid_valid <= skid_nxt;
        rdy_r      <= ~skid_nxt;
        if (!skid_valid && valid_up && rdy_r && !ready_down) skid_data <= data_up;
      end
    end

  end else if (MODE == HS_FULL) begin : g_full
    logic [1:0]            state, state_nxt;
    logic [DATA_WIDTH-1:0] m_data, s_data;
    logic                  rdy_r, accept, consume;

    assign accept     = valid_up & rdy_r;
    assign consume    = (state != EMPTY) & ready_down;
    assign ready_up   = rdy_r;
    assign valid_down = (state != EMPTY);
    assign data_down  = m_data;
    assign occupancy  = state;

    always_comb begin
      state_nxt = state;
      case (state)
        EMPTY: if (accept) state_nxt = BUSY;
        BUSY: begin
          if (accept && !consume)      state_nxt = FULL;
          else if (consume && !accept) state_nxt = EMPTY;
        end
        FULL:    if (consume) state_nxt = BUSY;
        default: state_nxt = EMPTY;
      endcase
    end

    // ready_up is registered from the next state so no input reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= EMPTY;
        rdy_r  <= 1'b0;
        m_data <= '0;
        s_data <= '0;
      end else begin
        state <= state_nxt;
        rdy_r <= (state_nxt != FULL);
        if (accept && (state == EMPTY || consume)) m_data <= data_up;
        else if (state == FULL && consume)         m_data <= s_data;
        if (state == BUSY && accept && !consume)   s_data <= data_up;
      end
    end

  end else begin : g_bad
    $error("axi_reg_slice: illegal MODE %0d (ok=%0d)", MODE, hs_mode_ok(MODE));
  end

endmodule

// File: tb/tb_axi_reg_slice.sv
// Drives all four slice modes in parallel from shared inputs; a queue model per mode predicts outputs.
module tb_axi_reg_slice;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_up;
  logic        valid_up, ready_down;
  logic [3:0]  ru, vd;
  logic [31:0] dd [4];
  logic [1:0]  oc [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_reg_slice #(.DATA_WIDTH(32), .MODE(0)) u0 (.clk(clk), .rst(rst), .data_up(data_up), .valid_up(valid_up),
    .ready_up(ru[0]), .data_down(dd[0]), .valid_down(vd[0]), .ready_down(ready_down), .occupancy(oc[0]));
  axi_reg_slice #(.DATA_WIDTH(32), .MODE(1)) u1 (.clk(clk), .rst(rst), .data_up(data_up), .valid_up(valid_up),
    .ready_up(ru[1]), .data_down(dd[1]), .valid_down(vd[1]), .ready_down(ready_down), .occupancy(oc[1]));
  axi_reg_slice #(.DATA_WIDTH(32), .MODE(2)) u2 (.clk(clk), .rst(rst), .data_up(data_up), .valid_up(valid_up),
    .ready_up(ru[2]), .data_down(dd[2]), .valid_down(vd[2]), .ready_down(ready_down), .occupancy(oc[2]));
  axi_reg_slice #(.DATA_WIDTH(32), .MODE(3)) u3 (.clk(clk), .rst(rst), .data_up(data_up), .valid_up(valid_up),
    .ready_up(ru[3]), .data_down(dd[3]), .valid_down(vd[3]), .ready_down(ready_down), .occupancy(oc[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: each queue holds beats accepted on earlier edges and not yet consumed.
  logic [31:0] q1[$], q2[$], q3[$];
  logic        started;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q1.delete(); q2.delete(); q3.delete();
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (q1.size() > 0 && ready_down) begin
        if (valid_up) q1.push_back(data_up);
        q1.delete(0);
      end else if (valid_up && q1.size() == 0) q1.push_back(data_up);
      if (q2.size() > 0) begin
        if (ready_down) q2.delete(0);
      end else if (started && valid_up && !ready_down) q2.push_back(data_up);
      if (q3.size() > 0 && ready_down) begin
        if (valid_up && started && q3.size() < 2) q3.push_back(data_up);
        q3.delete(0);
      end else if (valid_up && started && q3.size() < 2) q3.push_back(data_up);
    end
  end

  always @(negedge clk) begin
    chk("m0_valid", {31'b0, vd[0]}, {31'b0, valid_up});
    chk("m0_data", dd[0], data_up);
    chk("m0_ready", {31'b0, ru[0]}, {31'b0, ready_down});
    chk("m0_occ", {30'b0, oc[0]}, 32'd0);
    if (rst) begin
      chk("rst_valid", {28'b0, vd[3:1], 1'b0}, 32'd0);
      chk("rst_ready23", {30'b0, ru[3:2]}, 32'd0);
      chk("rst_occ", {26'b0, oc[1], oc[2], oc[3]}, 32'd0);
    end else begin
      chk("m1_valid", {31'b0, vd[1]}, (q1.size() > 0) ? 32'd1 : 32'd0);
      chk("m1_ready", {31'b0, ru[1]}, (ready_down || q1.size() == 0) ? 32'd1 : 32'd0);
      chk("m1_occ", {30'b0, oc[1]}, q1.size());
      if (q1.size() > 0) chk("m1_data", dd[1], q1[0]);
      chk("m2_valid", {31'b0, vd[2]}, (valid_up || q2.size() > 0) ? 32'd1 : 32'd0);
      chk("m2_ready", {31'b0, ru[2]}, (started && q2.size() == 0) ? 32'd1 : 32'd0);
      chk("m2_occ", {30'b0, oc[2]}, q2.size());
      if (q2.size() > 0) chk("m2_data", dd[2], q2[0]);
      else if (valid_up) chk("m2_data", dd[2], data_up);
      chk("m3_valid", {31'b0, vd[3]}, (q3.size() > 0) ? 32'd1 : 32'd0);
      chk("m3_ready", {31'b0, ru[3]}, (started && q3.size() < 2) ? 32'd1 : 32'd0);
      chk("m3_occ", {30'b0, oc[3]}, q3.size());
      if (q3.size() > 0) chk("m3_data", dd[3], q3[0]);
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    @(posedge clk); #1;
    valid_up = v; data_up = d; ready_down = r;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; valid_up = 1'b0; data_up = '0; ready_down = 1'b0;
    @(negedge clk);
    chk("lit_rst_ready3", {31'b0, ru[3]}, 32'd0);
    chk("lit_rst_data3", dd[3], 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("lit_ready3_pre_edge", {31'b0, ru[3]}, 32'd0);

    // Full slice streaming: one-cycle latency, back-to-back beats.
    for (int k = 1; k <= 9; k++) begin
      cyc(k <= 8, k, 1'b1);
      if (k >= 2) begin
        chk("lit_stream_data", dd[3], k - 1);
        chk("lit_stream_occ", {30'b0, oc[3]}, 32'd1);
        chk("lit_stream_ready", {31'b0, ru[3]}, 32'd1);
      end
    end
    drain(2);

    // Full slice backpressure: two held, third refused, all delivered in order.
    cyc(1'b1, 32'hA, 1'b0);
    cyc(1'b1, 32'hB, 1'b0);
    cyc(1'b1, 32'hC, 1'b0);
    chk("lit_full_occ", {30'b0, oc[3]}, 32'd2);
    chk("lit_full_ready", {31'b0, ru[3]}, 32'd0);
    chk("lit_full_data", dd[3], 32'hA);
    cyc(1'b1, 32'hC, 1'b1);
    chk("lit_full_out_a", dd[3], 32'hA);
    cyc(1'b1, 32'hC, 1'b1);
    chk("lit_full_out_b", dd[3], 32'hB);
    chk("lit_full_ready_back", {31'b0, ru[3]}, 32'd1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("lit_full_out_c", dd[3], 32'hC);
    drain(3);

    // Skid slice: stalled beat parks in skid and leaves first.
    cyc(1'b1, 32'h55, 1'b0);
    chk("lit_skid_pass", dd[2], 32'h55);
    cyc(1'b1, 32'h66, 1'b0);
    chk("lit_skid_ready_drop", {31'b0, ru[2]}, 32'd0);
    chk("lit_skid_held", dd[2], 32'h55);
    cyc(1'b1, 32'h66, 1'b1);
    chk("lit_skid_first", dd[2], 32'h55);
    cyc(1'b1, 32'h66, 1'b1);
    chk("lit_skid_ready_back", {31'b0, ru[2]}, 32'd1);
    chk("lit_skid_next", dd[2], 32'h66);
    drain(3);

    // Forward slice: valid_up under stall is not accepted.
    cyc(1'b1, 32'h11, 1'b0);
    cyc(1'b1, 32'h22, 1'b0);
    chk("lit_fwd_hold", dd[1], 32'h11);
    chk("lit_fwd_ready", {31'b0, ru[1]}, 32'd0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("lit_fwd_unchanged", dd[1], 32'h11);
    drain(3);

    // Async reset with the full slice holding two beats.
    cyc(1'b1, 32'hA1, 1'b0);
    cyc(1'b1, 32'hA2, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("lit_pre_rst_occ", {30'b0, oc[3]}, 32'd2);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("lit_arst_valid", {31'b0, vd[3]}, 32'd0);
    chk("lit_arst_occ", {30'b0, oc[3]}, 32'd0);
    chk("lit_arst_data3", dd[3], 32'd0);
    chk("lit_arst_data1", dd[1], 32'd0);
    chk("lit_arst_ready", {31'b0, ru[3]}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0; ready_down = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_ready3", {31'b0, ru[3]}, 32'd0);
    chk("lit_post_rst_ready2", {31'b0, ru[2]}, 32'd0);
    cyc(1'b0, 32'd0, 1'b1);
    chk("lit_ready3_up", {31'b0, ru[3]}, 32'd1);

    // Random traffic: model checks order, stability and flags every cycle.
    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));
    drain(4);
    chk("lit_end_occ3", {30'b0, oc[3]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
